// File: rtl/watch_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : watch_sequencer
//  Purpose  : Central sequencing controller for the stopwatch datapath.
//             Debounces the pause/reset buttons, synchronizes the adjust
//             switches, derives the 2 Hz / 1 Hz ticks from the master clock,
//             runs the RUN/PAUSE/ADJ_MIN/ADJ_SEC mode machine and issues
//             single-cycle increment/clear strobes plus blink enables.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLK_HZ           master clock frequency (must be even)
//    DEBOUNCE_CYCLES  cycles a synchronized button must hold a new level
//    BLINK_HZ         blink toggle-pair rate; CLK_HZ/(2*BLINK_HZ) integral
//  Ports
//    clk        in   master clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    btn_pause  in   raw pause button, active-high, asynchronous
//    btn_reset  in   raw reset button, active-high, asynchronous
//    sw_sel     in   adjust field select: 0 = minutes, 1 = seconds
//    sw_adj     in   adjust mode enable
//    inc_sec    out  one-cycle strobe: increment seconds
//    inc_min    out  one-cycle strobe: increment minutes
//    carry_en   out  seconds rollover carries into minutes when high
//    cnt_clr    out  one-cycle strobe: clear all digits to 00:00
//    blink_min  out  blank minute digits while high
//    blink_sec  out  blank second digits while high
//    mode       out  00 RUN, 01 PAUSE, 10 ADJ_MIN, 11 ADJ_SEC
//  Configuration
//    WATCH_SEQ_BLINK_EN  when defined the blink divider is built; otherwise
//                        blink_min / blink_sec are tied low in all modes.
// ============================================================================
module watch_sequencer #(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HZ        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_sel,
  input  logic       sw_adj,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       carry_en,
  output logic       cnt_clr,
  output logic       blink_min,
  output logic       blink_sec,
  output logic [1:0] mode
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int HALF_CYCLES = CLK_HZ / 2;
  localparam int PRE_W       = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam int DB_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Elaboration-time parameter sanity checks
  if ((CLK_HZ % 2) != 0) begin : g_chk_clk_even
    $error("watch_sequencer: CLK_HZ must be even");
  end
  if ((BLINK_HZ < 1) || ((CLK_HZ % (2 * BLINK_HZ)) != 0)) begin : g_chk_blink
    $error("watch_sequencer: CLK_HZ/(2*BLINK_HZ) must be an integer");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("watch_sequencer: DEBOUNCE_CYCLES must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Mode encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PAUSE   = 2'b01,
    ST_ADJ_MIN = 2'b10,
    ST_ADJ_SEC = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Button path: 2-FF synchronizer + stability counter, one instance per
  // button. Bit 0 = pause, bit 1 = reset.
  // --------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_press;

  assign w_btn_raw = {btn_reset, btn_pause};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    // r_cnt counts consecutive samples where the synchronized input
    // disagrees with the accepted level; any agreeing sample restarts it,
    // so a bounce shorter than DEBOUNCE_CYCLES never gets accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_btn_raw[gi];
        r_s2    <= r_s1;
        r_press <= 1'b0;
        if (r_s2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt   <= '0;
          r_level <= r_s2;
          // Only an accepted rising level produces a press pulse.
          r_press <= r_s2;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end
    end

    assign w_btn_press[gi] = r_press;
  end

  logic w_pause_press;
  logic w_reset_press;

  assign w_pause_press = w_btn_press[0];
  assign w_reset_press = w_btn_press[1];

  // --------------------------------------------------------------------------
  // Switch path: 2-FF synchronizer only. Bit 0 = sw_adj, bit 1 = sw_sel.
  // --------------------------------------------------------------------------
  logic [1:0] r_sw_s1;
  logic [1:0] r_sw_s2;
  logic       w_adj;
  logic       w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1 <= 2'b00;
      r_sw_s2 <= 2'b00;
    end else begin
      r_sw_s1 <= {sw_sel, sw_adj};
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign w_adj = r_sw_s2[0];
  assign w_sel = r_sw_s2[1];

  // --------------------------------------------------------------------------
  // Prescaler: half_tick on each wrap (2 Hz), sec_tick on every second
  // half_tick (1 Hz). A reset press restarts both count and phase so the
  // next full second starts exactly at the clear.
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0] r_pre;
  logic             r_half_phase;
  logic             w_half_tick;
  logic             w_sec_tick;

  assign w_half_tick = (r_pre == PRE_W'(HALF_CYCLES - 1));
  assign w_sec_tick  = w_half_tick & r_half_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_half_phase <= 1'b0;
    end else if (w_reset_press) begin
      r_pre        <= '0;
      r_half_phase <= 1'b0;
    end else if (w_half_tick) begin
      r_pre        <= '0;
      r_half_phase <= ~r_half_phase;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Blink divider
  // --------------------------------------------------------------------------
  logic w_blink_phase;

`ifdef WATCH_SEQ_BLINK_EN
  localparam int BLINK_CYCLES = CLK_HZ / (2 * BLINK_HZ);
  localparam int BL_W         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BL_W'(1);
    end
  end

  assign w_blink_phase = r_blink_phase;
`else
  assign w_blink_phase = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Mode machine and registered outputs
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;
  logic   r_run;
  logic   w_run_next;
  logic   r_inc_sec;
  logic   r_inc_min;
  logic   r_carry_en;
  logic   r_cnt_clr;
  logic   r_blink_min;
  logic   r_blink_sec;
  logic   w_inc_sec_next;
  logic   w_inc_min_next;
  logic   w_carry_en_next;
  logic   w_cnt_clr_next;
  logic   w_blink_min_next;
  logic   w_blink_sec_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_run       <= 1'b1;
      r_inc_sec   <= 1'b0;
      r_inc_min   <= 1'b0;
      r_carry_en  <= 1'b1;
      r_cnt_clr   <= 1'b0;
      r_blink_min <= 1'b0;
      r_blink_sec <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_run       <= w_run_next;
      r_inc_sec   <= w_inc_sec_next;
      r_inc_min   <= w_inc_min_next;
      r_carry_en  <= w_carry_en_next;
      r_cnt_clr   <= w_cnt_clr_next;
      r_blink_min <= w_blink_min_next;
      r_blink_sec <= w_blink_sec_next;
    end
  end

  // Strobes are selected from the *next* mode so that a tick coinciding with
  // a mode change already follows the new mode.
  always_comb begin
    w_state_next     = r_state;
    w_run_next       = r_run;
    w_inc_sec_next   = 1'b0;
    w_inc_min_next   = 1'b0;
    w_carry_en_next  = 1'b1;
    w_cnt_clr_next   = 1'b0;
    w_blink_min_next = 1'b0;
    w_blink_sec_next = 1'b0;

    // Pause presses while the adjust switch is on are dropped.
    if (w_pause_press && !w_adj) begin
      w_run_next = ~r_run;
    end

    if (w_adj) begin
      w_state_next = w_sel ? ST_ADJ_SEC : ST_ADJ_MIN;
    end else begin
      w_state_next = w_run_next ? ST_RUN : ST_PAUSE;
    end

    case (w_state_next)
      ST_RUN: begin
        w_inc_sec_next  = w_sec_tick;
        w_carry_en_next = 1'b1;
      end
      ST_PAUSE: begin
        w_carry_en_next = 1'b1;
      end
      ST_ADJ_MIN: begin
        w_inc_min_next   = w_half_tick;
        w_carry_en_next  = 1'b0;
        w_blink_min_next = w_blink_phase;
      end
      ST_ADJ_SEC: begin
        w_inc_sec_next   = w_half_tick;
        w_carry_en_next  = 1'b0;
        w_blink_sec_next = w_blink_phase;
      end
      default: begin
        w_carry_en_next = 1'b1;
      end
    endcase

    // A clear suppresses any increment in the same cycle; mode and run flag
    // are left as computed above.
    if (w_reset_press) begin
      w_cnt_clr_next = 1'b1;
      w_inc_sec_next = 1'b0;
      w_inc_min_next = 1'b0;
    end
  end

  assign inc_sec   = r_inc_sec;
  assign inc_min   = r_inc_min;
  assign carry_en  = r_carry_en;
  assign cnt_clr   = r_cnt_clr;
  assign blink_min = r_blink_min;
  assign blink_sec = r_blink_sec;
  assign mode      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_watch_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_watch_sequencer
//  Purpose  : Self-checking bench for watch_sequencer. A cycle-level model
//             built from input history windows and elapsed-cycle counters
//             predicts every output on every clock; directed scenarios add
//             hand-computed latency and pulse-count expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_watch_sequencer;

  localparam int CLK_HZ   = 20;
  localparam int DEB      = 4;
  localparam int BLINK_HZ = 2;
  localparam int HALF     = CLK_HZ / 2;
  localparam int SEC      = CLK_HZ;
  localparam int BLINK_T  = CLK_HZ / (2 * BLINK_HZ);
`ifdef WATCH_SEQ_BLINK_EN
  localparam int BLINK_TOGGLES = 8;
  localparam bit BLINK_ON      = 1'b1;
`else
  localparam int BLINK_TOGGLES = 0;
  localparam bit BLINK_ON      = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_sel = 1'b0;
  logic       sw_adj = 1'b0;
  logic       inc_sec;
  logic       inc_min;
  logic       carry_en;
  logic       cnt_clr;
  logic       blink_min;
  logic       blink_sec;
  logic [1:0] mode;

  watch_sequencer #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_HZ       (BLINK_HZ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_pause(btn_pause),
    .btn_reset(btn_reset),
    .sw_sel   (sw_sel),
    .sw_adj   (sw_adj),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .carry_en (carry_en),
    .cnt_clr  (cnt_clr),
    .blink_min(blink_min),
    .blink_sec(blink_sec),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- model state ----------------
  // h*[0] is the raw level seen at the current edge, h*[k] k edges ago.
  logic [DEB+1:0] hp, hr, ha, hs;
  logic           m_db_p, m_db_r;      // accepted button levels
  logic           m_pend_p, m_pend_r;  // press accepted at the previous edge
  logic           m_run;
  int             m_t;                 // cycles since prescaler restart
  int             m_b;                 // cycles since reset (blink time)
  logic           e_inc_sec, e_inc_min, e_carry, e_clr, e_bmin, e_bsec;
  logic [1:0]     e_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // True when the synchronized view (raw delayed by two) has held lvl for
  // DEB consecutive edges.
  function automatic logic held(input logic [DEB+1:0] h, input logic lvl);
    for (int i = 2; i <= DEB + 1; i++) begin
      if (h[i] !== lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    logic       adj, sel, run_n, half, sec, phase;
    logic [1:0] md;
    if (!rst_n) begin
      hp = '0; hr = '0; ha = '0; hs = '0;
      m_db_p = 1'b0; m_db_r = 1'b0; m_pend_p = 1'b0; m_pend_r = 1'b0;
      m_run = 1'b1; m_t = 0; m_b = 0;
      e_mode = 2'b00; e_carry = 1'b1;
      e_inc_sec = 1'b0; e_inc_min = 1'b0; e_clr = 1'b0; e_bmin = 1'b0; e_bsec = 1'b0;
      return;
    end
    hp = {hp[DEB:0], btn_pause};
    hr = {hr[DEB:0], btn_reset};
    ha = {ha[DEB:0], sw_adj};
    hs = {hs[DEB:0], sw_sel};
    adj   = ha[2];
    sel   = hs[2];
    run_n = m_run ^ (m_pend_p & ~adj);
    if (adj) md = {1'b1, sel};
    else     md = run_n ? 2'd0 : 2'd1;
    half  = (m_t % HALF) == HALF - 1;
    sec   = (m_t % SEC) == SEC - 1;
    phase = ((m_b / BLINK_T) % 2) == 1;

    e_mode    = md;
    e_carry   = (md == 2'd0) || (md == 2'd1);
    e_clr     = m_pend_r;
    e_inc_sec = !m_pend_r && (((md == 2'd0) && sec) || ((md == 2'd3) && half));
    e_inc_min = !m_pend_r && (md == 2'd2) && half;
    e_bmin    = BLINK_ON && (md == 2'd2) && phase;
    e_bsec    = BLINK_ON && (md == 2'd3) && phase;

    m_run = run_n;
    m_t   = m_pend_r ? 0 : m_t + 1;
    m_b   = m_b + 1;
    m_pend_p = 1'b0;
    if (held(hp, ~m_db_p)) begin
      m_db_p   = ~m_db_p;
      m_pend_p = m_db_p;
    end
    m_pend_r = 1'b0;
    if (held(hr, ~m_db_r)) begin
      m_db_r   = ~m_db_r;
      m_pend_r = m_db_r;
    end
  endtask

  // One clock: advance the model at the edge, compare every output just
  // after it, return at the falling edge where stimulus is applied.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("mode", 32'(mode), 32'(e_mode));
    chk("inc_sec", 32'(inc_sec), 32'(e_inc_sec));
    chk("inc_min", 32'(inc_min), 32'(e_inc_min));
    chk("carry_en", 32'(carry_en), 32'(e_carry));
    chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
    chk("blink_min", 32'(blink_min), 32'(e_bmin));
    chk("blink_sec", 32'(blink_sec), 32'(e_bsec));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_sec, n_min, first, lat, lat2, clr_n, clr_at, sec_after, tog;
    logic prev;

    // ---- reset ----
    @(negedge clk);
    repeat (3) tick();
    chk("rst_mode", 32'(mode), 0);
    chk("rst_carry", 32'(carry_en), 1);
    chk("rst_clr", 32'(cnt_clr), 0);

    // ---- free run: inc_sec every 20 cycles, first at the 20th edge ----
    rst_n = 1'b1;
    n_sec = 0; n_min = 0; first = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (inc_sec) begin n_sec++; if (first < 0) first = i; end
      if (inc_min) n_min++;
    end
    chk("run_sec_count", 32'(n_sec), 3);
    chk("run_first_sec", 32'(first), 20);
    chk("run_min_count", 32'(n_min), 0);

    // ---- pause press: mode=01 after 2 sync + 4 debounce + 1 register ----
    btn_pause = 1'b1; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat < 0 && mode == 2'b01) lat = i;
    end
    btn_pause = 1'b0;
    chk("pause_latency", 32'(lat), 7);
    n_sec = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inc_sec) n_sec++;
    end
    chk("pause_no_sec", 32'(n_sec), 0);
    chk("pause_mode", 32'(mode), 1);
    btn_pause = 1'b1; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat < 0 && mode == 2'b00) lat = i;
    end
    btn_pause = 1'b0;
    chk("resume_latency", 32'(lat), 7);
    repeat (10) tick();

    // ---- bouncing reset button: single clear, next second 20 cycles on ----
    clr_n = 0; clr_at = -1; sec_after = -1;
    for (int i = 0; i < 60; i++) begin
      btn_reset = (i < 12) ? ((i % 4) < 2) : (i < 24);
      tick();
      if (cnt_clr) begin clr_n++; if (clr_at < 0) clr_at = i; end
      if (inc_sec && clr_at >= 0 && sec_after < 0) sec_after = i;
    end
    btn_reset = 1'b0;
    chk("bounce_clr_count", 32'(clr_n), 1);
    chk("bounce_clr_at", 32'(clr_at), 18);
    chk("clr_to_sec", 32'(sec_after - clr_at), 20);

    // ---- adjust minutes ----
    sw_adj = 1'b1; sw_sel = 1'b0; lat = -1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (lat < 0 && mode == 2'b10) lat = i;
    end
    chk("adj_min_latency", 32'(lat), 3);
    n_min = 0; n_sec = 0; tog = 0; prev = blink_min;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inc_min) n_min++;
      if (inc_sec) n_sec++;
      if (blink_min != prev) tog++;
      prev = blink_min;
    end
    chk("adj_min_inc_min", 32'(n_min), 4);
    chk("adj_min_inc_sec", 32'(n_sec), 0);
    chk("adj_min_blink_toggles", 32'(tog), 32'(BLINK_TOGGLES));
    chk("adj_min_carry", 32'(carry_en), 0);

    // ---- adjust seconds ----
    sw_sel = 1'b1; lat = -1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (lat < 0 && mode == 2'b11) lat = i;
    end
    chk("adj_sec_latency", 32'(lat), 3);
    n_min = 0; n_sec = 0; tog = 0; prev = blink_sec;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inc_min) n_min++;
      if (inc_sec) n_sec++;
      if (blink_sec != prev) tog++;
      prev = blink_sec;
    end
    chk("adj_sec_inc_sec", 32'(n_sec), 4);
    chk("adj_sec_inc_min", 32'(n_min), 0);
    chk("adj_sec_blink_toggles", 32'(tog), 32'(BLINK_TOGGLES));

    // ---- pause press during adjust is dropped ----
    sw_sel = 1'b0;
    repeat (3) tick();
    btn_pause = 1'b1;
    repeat (10) tick();
    btn_pause = 1'b0;
    repeat (8) tick();
    sw_adj = 1'b0;
    repeat (3) tick();
    chk("adj_pause_dropped", 32'(mode), 0);

    // ---- simultaneous reset + pause in RUN ----
    btn_pause = 1'b1; btn_reset = 1'b1;
    lat = -1; lat2 = -1; clr_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cnt_clr) begin clr_n++; if (lat < 0) lat = i; end
      if (lat2 < 0 && mode == 2'b01) lat2 = i;
    end
    btn_pause = 1'b0; btn_reset = 1'b0;
    chk("both_clr_count", 32'(clr_n), 1);
    chk("both_clr_latency", 32'(lat), 7);
    chk("both_pause_latency", 32'(lat2), 7);
    repeat (10) tick();

    // ---- reset asserted mid-debounce ----
    for (int i = 0; i < 40 && (m_t % SEC) != 15; i++) tick();
    chk("align_prescaler", 32'(m_t % SEC), 15);
    btn_pause = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_mode", 32'(mode), 0);
    chk("async_rst_carry", 32'(carry_en), 1);
    chk("async_rst_strobes", 32'({inc_sec, inc_min, cnt_clr, blink_min, blink_sec}), 0);
    btn_pause = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mode != 2'b00) lat++;
    end
    chk("no_press_after_rst", 32'(lat), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
